// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux
//  Brief    : N-to-1 valid/ready stream multiplexer with a registered output
//             stage. Channel choice is either a fixed select or round-robin
//             starting after the last granted channel.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        mode,
    input  logic [$clog2(CHANNELS)-1:0] select,
    input  logic [CHANNELS*WIDTH-1:0]   inData,
    input  logic [CHANNELS-1:0]         inValid,
    output logic [CHANNELS-1:0]         inReady,
    output logic [WIDTH-1:0]            out,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [$clog2(CHANNELS)-1:0] outChannel
);

    localparam int SEL_WIDTH = $clog2(CHANNELS);

    // Reset value of the pointer, so that channel 0 has first priority.
    localparam logic [SEL_WIDTH-1:0] c_LAST_CHANNEL = SEL_WIDTH'(CHANNELS - 1);

    logic [SEL_WIDTH-1:0] r_ptr;        // last channel granted in round-robin
    logic [SEL_WIDTH-1:0] w_rrGrant;
    logic [SEL_WIDTH-1:0] w_rrIdx;
    logic                 w_rrFound;
    logic [SEL_WIDTH-1:0] w_grant;
    logic                 w_load;
    logic                 w_xfer;
    logic [WIDTH-1:0]     w_selData;

    // Round-robin search: first valid channel upward from ptr+1, wrapping.
    // CHANNELS is a power of two, so the SEL_WIDTH-bit sum wraps naturally.
    always_comb begin
        w_rrFound = 1'b0;
        w_rrGrant = r_ptr + SEL_WIDTH'(1);
        w_rrIdx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_rrIdx = r_ptr + SEL_WIDTH'(k);
            if (!w_rrFound && inValid[w_rrIdx]) begin
                w_rrFound = 1'b1;
                w_rrGrant = w_rrIdx;
            end
        end
    end

    // The output register may accept a new word when empty or draining.
    assign w_load  = !outValid || outReady;
    assign w_grant = mode ? w_rrGrant : select;
    assign w_xfer  = w_load && inValid[w_grant];

    // Ready goes only to the granted channel, independent of its valid.
    always_comb begin
        inReady = '0;
        if (w_load) begin
            inReady[w_grant] = 1'b1;
        end
    end

    // Pick the granted channel's data word out of the packed bus.
    always_comb begin
        w_selData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_WIDTH'(i)) begin
                w_selData = inData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; drain and refill can coincide.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            out        <= '0;
            outValid   <= 1'b0;
            outChannel <= '0;
            r_ptr      <= c_LAST_CHANNEL;
        end else begin
            if (w_xfer) begin
                out        <= w_selData;
                outChannel <= w_grant;
                outValid   <= 1'b1;
                if (mode) begin
                    r_ptr <= w_grant;
                end
            end else if (outReady) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
